// File: rtl/synth_pkg.sv
// Shared types and helpers for the harmonic sine synthesizer.
// State encoding, datapath widths and output saturation.
package synth_pkg;

  localparam int NUM_HARMONICS = 5;
  localparam int ACC_WIDTH     = 36;
  localparam int SAMPLE_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MAC    = 2'd2,
    OUTPUT = 2'd3
  } state_e;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = 36'sd32767;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -36'sd32768;

  function automatic logic signed [SAMPLE_WIDTH-1:0] sat16(
    input logic signed [ACC_WIDTH-1:0] v
  );
    if (v > SAT_MAX) begin
      return 16'sh7FFF;
    end else if (v < SAT_MIN) begin
      return 16'sh8000;
    end else begin
      return v[SAMPLE_WIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/sine_lut.sv
// Registered full-wave sine table built from a 65-entry quarter wave.
// Entry i = round(32767*sin(2*pi*i/256)); narrower address spaces index it coarsely.
module sine_lut #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  output logic signed [15:0]    data_out
);

  localparam logic [15:0] QTAB [65] = '{
    16'd0,     16'd804,   16'd1608,  16'd2410,
    16'd3212,  16'd4011,  16'd4808,  16'd5602,
    16'd6393,  16'd7179,  16'd7962,  16'd8739,
    16'd9512,  16'd10278, 16'd11039, 16'd11793,
    16'd12539, 16'd13279, 16'd14010, 16'd14732,
    16'd15446, 16'd16151, 16'd16846, 16'd17530,
    16'd18204, 16'd18868, 16'd19519, 16'd20159,
    16'd20787, 16'd21403, 16'd22005, 16'd22594,
    16'd23170, 16'd23731, 16'd24279, 16'd24811,
    16'd25329, 16'd25832, 16'd26319, 16'd26790,
    16'd27245, 16'd27683, 16'd28105, 16'd28510,
    16'd28898, 16'd29268, 16'd29621, 16'd29956,
    16'd30273, 16'd30571, 16'd30852, 16'd31113,
    16'd31356, 16'd31580, 16'd31785, 16'd31971,
    16'd32137, 16'd32285, 16'd32412, 16'd32521,
    16'd32609, 16'd32678, 16'd32728, 16'd32757,
    16'd32767
  };

  logic [7:0]         a8;
  logic [6:0]         idx;
  logic signed [15:0] mag;
  logic signed [15:0] val;

  generate
    if (ADDR_WIDTH >= 8) begin : g_wide
      assign a8 = addr_in[ADDR_WIDTH-1 -: 8];
    end else begin : g_narrow
      assign a8 = {addr_in, {(8-ADDR_WIDTH){1'b0}}};
    end
  endgenerate

  // Odd quadrants mirror the index, upper half negates.
  always_comb begin
    idx = {1'b0, a8[5:0]};
    if (a8[6]) begin
      idx = 7'd64 - {1'b0, a8[5:0]};
    end
    mag = $signed(QTAB[idx]);
    val = a8[7] ? -mag : mag;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      data_out <= '0;
    end else begin
      data_out <= val;
    end
  end

endmodule

// File: rtl/harmonic_sine_synth.sv
// Additive synthesizer: per tick, sums magnitude-weighted sines of harmonics
// 1..N of a programmable fundamental through one shared LUT and multiplier.
module harmonic_sine_synth #(
  parameter int NUM_HARMONICS  = synth_pkg::NUM_HARMONICS,
  parameter int MAG_WIDTH      = 32,
  parameter int PHASE_WIDTH    = 32,
  parameter int LUT_ADDR_WIDTH = 8,
  parameter int OUT_SHIFT      = 19
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     valid_data_in,
  input  logic [NUM_HARMONICS-1:0]
               [MAG_WIDTH-1:0]     coeff_mags_in,
  input  logic [PHASE_WIDTH-1:0]   base_phase_inc_in,
  input  logic                     sample_tick_in,
  output logic signed [15:0]       sample_out,
  output logic                     sample_valid_out,
  output logic                     mags_loaded_out,
  output logic                     busy_out,
  output logic                     overrun_out
);

  import synth_pkg::*;

  localparam int KW = (NUM_HARMONICS > 1) ? $clog2(NUM_HARMONICS) : 1;
  localparam int PW = PHASE_WIDTH;

  typedef logic [NUM_HARMONICS-1:0][15:0]   mag_bank_t;
  typedef logic [NUM_HARMONICS-1:0][PW-1:0] phase_bank_t;

  state_e                       state_q, state_d;
  logic [KW-1:0]                k_q, k_d;
  logic [PW-1:0]                step_q, step_d;
  logic [PW-1:0]                inc_q, inc_d;
  logic [PW-1:0]                sinc_q, sinc_d;
  mag_bank_t                    mag_q, mag_d;
  mag_bank_t                    shadow_q, shadow_d;
  phase_bank_t                  phase_q, phase_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic signed [15:0]           sample_q, sample_d;
  logic                         svalid_q, svalid_d;
  logic                         loaded_q, loaded_d;
  logic                         overrun_q, overrun_d;

  logic signed [15:0]           lut_data;
  logic signed [32:0]           prod;
  logic signed [ACC_WIDTH-1:0]  shifted;
  logic                         unused_mag_lsbs;

  assign unused_mag_lsbs = ^coeff_mags_in;

  sine_lut #(
    .ADDR_WIDTH (LUT_ADDR_WIDTH)
  ) u_lut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .addr_in  (phase_q[k_q][PW-1 -: LUT_ADDR_WIDTH]),
    .data_out (lut_data)
  );

  assign prod    = $signed({1'b0, mag_q[k_q]}) * lut_data;
  assign shifted = acc_q >>> OUT_SHIFT;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    step_d    = step_q;
    inc_d     = inc_q;
    sinc_d    = sinc_q;
    mag_d     = mag_q;
    shadow_d  = shadow_q;
    phase_d   = phase_q;
    acc_d     = acc_q;
    sample_d  = sample_q;
    svalid_d  = 1'b0;
    loaded_d  = loaded_q;
    overrun_d = overrun_q;

    if (valid_data_in) begin
      for (int k = 0; k < NUM_HARMONICS; k++) begin
        shadow_d[k] = coeff_mags_in[k][MAG_WIDTH-1 -: 16];
      end
      sinc_d   = base_phase_inc_in;
      loaded_d = 1'b1;
    end

    // Commit reads the _d shadow so a same-edge load takes effect.
    unique case (state_q)
      IDLE: begin
        if (sample_tick_in && loaded_d) begin
          mag_d   = shadow_d;
          inc_d   = sinc_d;
          step_d  = sinc_d;
          k_d     = '0;
          acc_d   = '0;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        state_d = MAC;
      end
      MAC: begin
        acc_d          = acc_q + {{(ACC_WIDTH-33){prod[32]}}, prod};
        phase_d[k_q]   = phase_q[k_q] + step_q;
        step_d         = step_q + inc_q;
        k_d            = k_q + KW'(1);
        state_d        = (k_q == KW'(NUM_HARMONICS-1)) ? OUTPUT : LOOKUP;
      end
      OUTPUT: begin
        sample_d = sat16(shifted);
        svalid_d = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (sample_tick_in && state_q != IDLE) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      k_q       <= '0;
      step_q    <= '0;
      inc_q     <= '0;
      sinc_q    <= '0;
      mag_q     <= '0;
      shadow_q  <= '0;
      phase_q   <= '0;
      acc_q     <= '0;
      sample_q  <= '0;
      svalid_q  <= 1'b0;
      loaded_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      step_q    <= step_d;
      inc_q     <= inc_d;
      sinc_q    <= sinc_d;
      mag_q     <= mag_d;
      shadow_q  <= shadow_d;
      phase_q   <= phase_d;
      acc_q     <= acc_d;
      sample_q  <= sample_d;
      svalid_q  <= svalid_d;
      loaded_q  <= loaded_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample_out       = sample_q;
  assign sample_valid_out = svalid_q;
  assign mags_loaded_out  = loaded_q;
  assign busy_out         = (state_q != IDLE);
  assign overrun_out      = overrun_q;

endmodule
